// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_ctrl
// Brief    : Run/pause/single-step controller producing MU0 step enables.
// Revision : 1.0
// ============================================================================
module step_ctrl #(
    parameter int STEP_DIV = 13500000,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       halt,
    output logic       step_en,
    output logic       running,
    output logic       halted,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        S_PAUSED  = 2'd0,
        S_RUNNING = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_term = CNT_W'(STEP_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_nxt;
    logic             r_prev_run;
    logic             r_prev_step;
    logic             r_step_en;
    logic             r_running;
    logic             r_halted;
    logic [7:0]       r_step_count;
    logic             w_step_nxt;
    logic             w_run_rise;
    logic             w_step_rise;

    assign w_run_rise  = btn_run  & ~r_prev_run;
    assign w_step_rise = btn_step & ~r_prev_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PAUSED;
            r_div        <= '0;
            r_prev_run   <= 1'b0;
            r_prev_step  <= 1'b0;
            r_step_en    <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_step_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_prev_run  <= btn_run;
            r_prev_step <= btn_step;
            r_step_en   <= w_step_nxt;
            r_running   <= (w_state_nxt == S_RUNNING);
            r_halted    <= (w_state_nxt == S_HALTED);
            if (w_step_nxt) begin
                r_step_count <= r_step_count + 8'd1;
            end
        end
    end

    // Priority within each state: halt, then run edge, then step/terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_step_nxt  = 1'b0;
        case (r_state)
            S_PAUSED: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (w_run_rise) begin
                    w_state_nxt = S_RUNNING;
                end else if (w_step_rise) begin
                    w_step_nxt = 1'b1;
                end
            end
            S_RUNNING: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (w_run_rise) begin
                    w_state_nxt = S_PAUSED;
                end else if (r_div == c_term) begin
                    w_step_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div + CNT_W'(1);
                end
            end
            S_HALTED: begin
                if (w_run_rise && !halt) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            default: begin
                w_state_nxt = S_PAUSED;
            end
        endcase
    end

    assign step_en    = r_step_en;
    assign running    = r_running;
    assign halted     = r_halted;
    assign step_count = r_step_count;

endmodule
`default_nettype wire
